fir_mac_sched: RTL and testbench

Sequencer for the time-shared symmetric FIR datapath. It runs in the `sys_clk` domain. On each `sam_clk_en` strobe it shifts one new sample into the delay line. It then steps one shared pre-adder/multiplier through every coefficient pair and controls the accumulator through the multiplier latency. It finishes by loading the filter output register. It sits between `clk_en` and the filter datapath, replacing the fully parallel multiplier array.

---
 rtl/fir_mac_sched_if.sv | 26 ++
 rtl/fir_mac_sched.sv | 135 +++++++++++++
 tb/tb_fir_mac_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sched_if.sv
// Control bundle between the FIR MAC sequencer and its neighbours.
// The sequencer sits on the slave side; the strobe source and datapath see it as master.
interface fir_mac_sched_if #(
  parameter int AW = 4
);
  logic          sam_clk_en;
  logic          clr_ovr;
  logic          ld_x;
  logic          mac_vld;
  logic [AW-1:0] pair_addr;
  logic          acc_en;
  logic          acc_clr;
  logic          y_ld;
  logic          busy;
  logic          overrun;

  modport master (
    output sam_clk_en, clr_ovr,
    input  ld_x, mac_vld, pair_addr, acc_en, acc_clr, y_ld, busy, overrun
  );

  modport slave (
    input  sam_clk_en, clr_ovr,
    output ld_x, mac_vld, pair_addr, acc_en, acc_clr, y_ld, busy, overrun
  );
endinterface

// File: rtl/fir_mac_sched.sv
// Sequencer for a time-shared symmetric FIR: one pre-add/multiply per coefficient
// pair per sample, accumulator control aligned to the multiplier latency.
//
// state | meaning
// IDLE  | waiting for a sample strobe
// SHIFT | new sample enters the delay line
// MAC   | one coefficient pair launched per cycle
// DRAIN | last products travelling through the multiplier
// DONE  | accumulator result loaded into y
module fir_mac_sched #(
  parameter int N_PAIRS  = 11,
  parameter int MULT_LAT = 2,
  parameter int AW       = 4
) (
  input  logic             clk,
  input  logic             reset,
  fir_mac_sched_if.slave   bus
);

  localparam int DW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [AW-1:0] LAST_PAIR = AW'(N_PAIRS - 1);
  localparam logic [DW-1:0] DRN_INIT  = DW'(MULT_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         drn_q, drn_d;
  logic                  ovr_q, ovr_d;

  logic                  ld_x_q, ld_x_d;
  logic                  mac_vld_q, mac_vld_d;
  logic [AW-1:0]         pair_addr_q, pair_addr_d;
  logic                  y_ld_q, y_ld_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [MULT_LAT-1:0]   vld_sr_q, vld_sr_d;
  logic [MULT_LAT-1:0]   first_sr_q, first_sr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    ovr_d   = ovr_q;
    if (bus.clr_ovr) ovr_d = 1'b0;

    // An ignored strobe is assigned after the clear so that set wins.
    unique case (state_q)
      S_IDLE: begin
        if (bus.sam_clk_en) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.sam_clk_en) ovr_d = 1'b1;
        cnt_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (bus.sam_clk_en) ovr_d = 1'b1;
        if (cnt_q == LAST_PAIR) begin
          cnt_d   = '0;
          drn_d   = DRN_INIT;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.sam_clk_en) ovr_d = 1'b1;
        if (drn_q == '0) state_d = S_DONE;
        else             drn_d   = drn_q - DW'(1);
      end
      S_DONE: begin
        state_d = bus.sam_clk_en ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_x_d      = (state_q == S_SHIFT);
    mac_vld_d   = (state_q == S_MAC);
    pair_addr_d = (state_q == S_MAC) ? cnt_q : '0;
    y_ld_d      = (state_q == S_DONE);
    busy_d      = (state_q != S_IDLE);
    overrun_d   = ovr_q;
    vld_sr_d    = MULT_LAT'({vld_sr_q, mac_vld_q});
    first_sr_d  = MULT_LAT'({first_sr_q, mac_vld_q && (pair_addr_q == '0)});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drn_q       <= '0;
      ovr_q       <= 1'b0;
      ld_x_q      <= 1'b0;
      mac_vld_q   <= 1'b0;
      pair_addr_q <= '0;
      y_ld_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      vld_sr_q    <= '0;
      first_sr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      ovr_q       <= ovr_d;
      ld_x_q      <= ld_x_d;
      mac_vld_q   <= mac_vld_d;
      pair_addr_q <= pair_addr_d;
      y_ld_q      <= y_ld_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      vld_sr_q    <= vld_sr_d;
      first_sr_q  <= first_sr_d;
    end
  end

  assign bus.ld_x      = ld_x_q;
  assign bus.mac_vld   = mac_vld_q;
  assign bus.pair_addr = pair_addr_q;
  assign bus.acc_en    = vld_sr_q[MULT_LAT-1];
  assign bus.acc_clr   = first_sr_q[MULT_LAT-1];
  assign bus.y_ld      = y_ld_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: cycle-exact control waveforms for two
// parameter sets plus an impulse run through a behavioural datapath.
module tb_fir_mac_sched;

  localparam int NP = 11;
  localparam int LA = 2;
  localparam int T  = 2 * NP - 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_mac_sched_if #(.AW(4)) ifa ();
  fir_mac_sched_if #(.AW(4)) ifb ();

  fir_mac_sched #(.N_PAIRS(NP), .MULT_LAT(LA), .AW(4)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  fir_mac_sched #(.N_PAIRS(1), .MULT_LAT(1), .AW(4)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // Behavioural symmetric-FIR datapath driven by u_a.
  int xd [T];
  int pp [LA];
  int acc;
  int y;
  int x_in;
  int hf [T] = '{3, -5, 7, 2, -1, 4, 6, -2, 9, 1, 8, 1, 9, -2, 6, 4, -1, 2, 7, -5, 3};

  function automatic int coef(input int p);
    case (p)
      0: return 3;   1: return -5;  2: return 7;  3: return 2;
      4: return -1;  5: return 4;   6: return 6;  7: return -2;
      8: return 9;   9: return 1;   10: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int pre_add(input int p);
    if (p == NP - 1) return xd[p];
    return xd[p] + xd[T - 1 - p];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < T; i++) xd[i] <= 0;
      for (int i = 0; i < LA; i++) pp[i] <= 0;
      acc <= 0;
      y   <= 0;
    end else begin
      if (ifa.ld_x) begin
        xd[0] <= x_in;
        for (int i = 1; i < T; i++) xd[i] <= xd[i-1];
      end
      pp[0] <= ifa.mac_vld ? coef(int'(ifa.pair_addr)) * pre_add(int'(ifa.pair_addr)) : 0;
      for (int i = 1; i < LA; i++) pp[i] <= pp[i-1];
      if (ifa.acc_en) acc <= ifa.acc_clr ? pp[LA-1] : acc + pp[LA-1];
      if (ifa.y_ld) y <= acc;
    end
  end

  task automatic chk1(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d got %0h exp %0h", tag, c, got, exp);
    end
  endtask

  // Expected control waveform from the documented timing, for accepted strobes ka/kb (<0 = none).
  task automatic chk_vec(input string tag, input int c, input int ka, input int kb,
                         input int n, input int l, input logic e_ov,
                         input logic ld, input logic mv, input logic [3:0] ad,
                         input logic ae, input logic ac, input logic yl,
                         input logic bz, input logic ov);
    logic       e_ld, e_mv, e_ae, e_ac, e_yl, e_bz;
    logic [3:0] e_ad;
    int         ks [2];
    e_ld = 0; e_mv = 0; e_ae = 0; e_ac = 0; e_yl = 0; e_bz = 0; e_ad = '0;
    ks[0] = ka; ks[1] = kb;
    for (int j = 0; j < 2; j++) begin
      if (ks[j] >= 0) begin
        if (c == ks[j] + 1) e_ld = 1;
        if (c >= ks[j] + 2 && c <= ks[j] + 1 + n) begin
          e_mv = 1;
          e_ad = 4'(c - ks[j] - 2);
        end
        if (c >= ks[j] + 2 + l && c <= ks[j] + 1 + n + l) e_ae = 1;
        if (c == ks[j] + 2 + l) e_ac = 1;
        if (c == ks[j] + 2 + n + l) e_yl = 1;
        if (c >= ks[j] + 1 && c <= ks[j] + 2 + n + l) e_bz = 1;
      end
    end
    chk1({tag, ".ld_x"},      c, 32'(ld), 32'(e_ld));
    chk1({tag, ".mac_vld"},   c, 32'(mv), 32'(e_mv));
    chk1({tag, ".pair_addr"}, c, 32'(ad), 32'(e_ad));
    chk1({tag, ".acc_en"},    c, 32'(ae), 32'(e_ae));
    chk1({tag, ".acc_clr"},   c, 32'(ac), 32'(e_ac));
    chk1({tag, ".y_ld"},      c, 32'(yl), 32'(e_yl));
    chk1({tag, ".busy"},      c, 32'(bz), 32'(e_bz));
    chk1({tag, ".overrun"},   c, 32'(ov), 32'(e_ov));
  endtask

  // Inputs are driven mid-cycle; strobes set here are sampled at the next edge.
  task automatic tick(input logic sa, input logic ca, input logic sb, input logic rst_v);
    ifa.sam_clk_en = sa;
    ifa.clr_ovr    = ca;
    ifb.sam_clk_en = sb;
    @(posedge clk);
    #1 reset = rst_v;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    x_in           = 0;
    ifa.sam_clk_en = 1'b0;
    ifa.clr_ovr    = 1'b0;
    ifb.sam_clk_en = 1'b0;
    ifb.clr_ovr    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk_vec("rst_a", 0, -1, -1, NP, LA, 1'b0, ifa.ld_x, ifa.mac_vld, ifa.pair_addr,
            ifa.acc_en, ifa.acc_clr, ifa.y_ld, ifa.busy, ifa.overrun);
    chk_vec("rst_b", 0, -1, -1, 1, 1, 1'b0, ifb.ld_x, ifb.mac_vld, ifb.pair_addr,
            ifb.acc_en, ifb.acc_clr, ifb.y_ld, ifb.busy, ifb.overrun);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);

    // Single strobe at cycle 0
    for (int c = 0; c <= 17; c++) begin
      tick(c == 0, 0, 0, 1);
      chk_vec("single", c, 0, -1, NP, LA, 1'b0, ifa.ld_x, ifa.mac_vld, ifa.pair_addr,
              ifa.acc_en, ifa.acc_clr, ifa.y_ld, ifa.busy, ifa.overrun);
    end

    // Back-to-back: second strobe lands in DONE
    for (int c = 0; c <= 33; c++) begin
      tick(c == 0 || c == 15, 0, 0, 1);
      chk_vec("b2b", c, 0, 15, NP, LA, 1'b0, ifa.ld_x, ifa.mac_vld, ifa.pair_addr,
              ifa.acc_en, ifa.acc_clr, ifa.y_ld, ifa.busy, ifa.overrun);
    end

    // Early strobe during MAC is ignored and flagged; cleared at 20
    for (int c = 0; c <= 23; c++) begin
      tick(c == 0 || c == 8, c == 20, 0, 1);
      chk_vec("early", c, 0, -1, NP, LA, (c >= 9 && c <= 20), ifa.ld_x, ifa.mac_vld,
              ifa.pair_addr, ifa.acc_en, ifa.acc_clr, ifa.y_ld, ifa.busy, ifa.overrun);
    end

    // Set wins over clear in the same cycle
    for (int c = 0; c <= 18; c++) begin
      tick(c == 0 || c == 5, c == 5 || c == 17, 0, 1);
      chk_vec("setwins", c, 0, -1, NP, LA, (c >= 6 && c <= 17), ifa.ld_x, ifa.mac_vld,
              ifa.pair_addr, ifa.acc_en, ifa.acc_clr, ifa.y_ld, ifa.busy, ifa.overrun);
    end

    // Reset asserted mid-MAC at 7, released at 9, fresh strobe at 12
    for (int c = 0; c <= 29; c++) begin
      tick(c == 0 || c == 12, 0, 0, !(c == 7 || c == 8));
      chk_vec("midrst", c, (c < 7) ? 0 : 12, -1, NP, LA, 1'b0, ifa.ld_x, ifa.mac_vld,
              ifa.pair_addr, ifa.acc_en, ifa.acc_clr, ifa.y_ld, ifa.busy, ifa.overrun);
    end

    // Minimal configuration: one pair, one-cycle multiplier
    for (int c = 0; c <= 6; c++) begin
      tick(0, 0, c == 0, 1);
      chk_vec("np1", c, 0, -1, 1, 1, 1'b0, ifb.ld_x, ifb.mac_vld, ifb.pair_addr,
              ifb.acc_en, ifb.acc_clr, ifb.y_ld, ifb.busy, ifb.overrun);
    end

    // Impulse through the datapath: y reproduces the full tap sequence
    for (int s = 0; s < T; s++) begin
      x_in = (s == 0) ? 1 : 0;
      for (int r = 0; r <= 16; r++) tick(r == 0, 0, 0, 1);
      chk1($sformatf("impulse.y[%0d]", s), s, 32'(y), 32'(hf[s]));
    end
    chk1("impulse.overrun", 0, 32'(ifa.overrun), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
